// File: rtl/adder_pkg.sv
// Shared width and operand type for the 6-bit adder slice.
package adder_pkg;
   localparam int ADDER_WIDTH = 6;
   typedef logic [ADDER_WIDTH-1:0] operand_t;
endpackage

// File: rtl/adder_6b_full_adder.sv
// One-bit full adder cell used as a ripple-carry stage.
module full_adder
   import adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_6b.sv
// Unsigned ripple-carry adder with a combinational sum and a one-cycle
// registered copy of {cout,S}.
module adder_6b
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic [WIDTH-1:0] S_r,
   output logic             cout_r
);

   logic [WIDTH:0] carry;
   logic [WIDTH:0] sum_d;
   logic [WIDTH:0] sum_q;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_adder u_fa (
         .a    (X[i]),
         .b    (Y[i]),
         .cin  (carry[i]),
         .s    (S[i]),
         .cout (carry[i+1])
      );
   end

   assign cout = carry[WIDTH];

   always_comb begin
      sum_d = {cout, S};
   end

   // Output register stage: reset clears the captured result only; S/cout stay live.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign S_r    = sum_q[WIDTH-1:0];
   assign cout_r = sum_q[WIDTH];

endmodule

// File: tb/tb_adder_6b.sv
// Self-checking bench for adder_6b: vector table, exhaustive sweep,
// random registered stream and reset sequences against an arithmetic model.
module tb_adder_6b;
   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] X, Y, S, S_r;
   logic         cout, cout_r;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adder_6b #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .X      (X),
      .Y      (Y),
      .S      (S),
      .cout   (cout),
      .S_r    (S_r),
      .cout_r (cout_r)
   );

   typedef struct {
      logic [5:0] x;
      logic [5:0] y;
      logic [5:0] s;
      logic       c;
   } vec_t;

   vec_t tbl[6];

   function automatic int model_sum(input int a, input int b);
      return (a + b) % 64;
   endfunction

   function automatic int model_cout(input int a, input int b);
      return ((a + b) >= 64) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   initial begin
      int idx;
      int px, py;

      tbl[0] = '{x: 6'b111111, y: 6'b000001, s: 6'b000000, c: 1'b1};
      tbl[1] = '{x: 6'b010101, y: 6'b101010, s: 6'b111111, c: 1'b0};
      tbl[2] = '{x: 6'd63,     y: 6'd63,     s: 6'd62,     c: 1'b1};
      tbl[3] = '{x: 6'd0,      y: 6'd0,      s: 6'd0,      c: 1'b0};
      tbl[4] = '{x: 6'd1,      y: 6'd63,     s: 6'd0,      c: 1'b1};
      tbl[5] = '{x: 6'd20,     y: 6'd22,     s: 6'd42,     c: 1'b0};

      rst = 1'b1;
      X   = '0;
      Y   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_S_r", S_r, 0);
      chk("reset_cout_r", cout_r, 0);

      for (int i = 0; i < 6; i++) begin
         X = tbl[i].x;
         Y = tbl[i].y;
         #1;
         chk($sformatf("table%0d_S", i), S, tbl[i].s);
         chk($sformatf("table%0d_cout", i), cout, tbl[i].c);
      end

      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            idx = a * 64 + b;
            X = a[5:0];
            Y = b[5:0];
            #1;
            total++;
            if ({cout, S} !== 7'(a + b)) begin
               bad++;
               $display("FAIL exhaustive vector %0d: got %0d expected %0d", idx, {cout, S}, a + b);
            end
         end
      end

      // rst held for two edges with 63+1: registered side stays zero, combinational side live.
      @(negedge clk);
      rst = 1'b1;
      X = 6'd63;
      Y = 6'd1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk("rsthold_S_r", S_r, 0);
         chk("rsthold_cout_r", cout_r, 0);
         chk("rsthold_S", S, 0);
         chk("rsthold_cout", cout, 1);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("release_S_r", S_r, 0);
      chk("release_cout_r", cout_r, 1);

      // Stream X=i, Y=2i mod 64 with a single reset pulse mid-stream.
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         X   = 6'(i);
         Y   = 6'((2 * i) % 64);
         rst = (i == 12);
         @(posedge clk);
         #1;
         if (i == 12) begin
            chk("stream_rst_S_r", S_r, 0);
            chk("stream_rst_cout_r", cout_r, 0);
         end else begin
            chk($sformatf("stream%0d_S_r", i), S_r, model_sum(i, (2 * i) % 64));
            chk($sformatf("stream%0d_cout_r", i), cout_r, model_cout(i, (2 * i) % 64));
         end
      end
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         px = int'($urandom_range(0, 63));
         py = int'($urandom_range(0, 63));
         X  = px[5:0];
         Y  = py[5:0];
         #1;
         chk("rand_S", S, model_sum(px, py));
         chk("rand_cout", cout, model_cout(px, py));
         @(posedge clk);
         #1;
         chk("rand_S_r", S_r, model_sum(px, py));
         chk("rand_cout_r", cout_r, model_cout(px, py));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
